// File: rtl/pong_game_sequencer.sv
// Frame-level pong controller: sequences serve/play/point/over phases, paces ball
// steps from the speed select, gates paddle pulses and keeps both scores.
module pong_game_sequencer #(
    parameter int WIN_SCORE    = 9,
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       left,
    input  logic       right,
    input  logic       score_reset,
    input  logic       speed_lsb,
    input  logic       speed_msb,
    input  logic       miss_left,
    input  logic       miss_right,
    output logic       ball_step,
    output logic       ball_hold,
    output logic       serve_dir,
    output logic       pad_left_up,
    output logic       pad_right_up,
    output logic [3:0] score_left,
    output logic [3:0] score_right,
    output logic       game_over,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        POINT = 3'd3,
        OVER  = 3'd4
    } state_t;

    localparam logic [3:0] WIN     = 4'(WIN_SCORE);
    localparam logic [7:0] SERVE_N = 8'(SERVE_FRAMES);
    localparam logic [7:0] POINT_N = 8'(POINT_FRAMES);

    logic [2:0] left_sync, right_sync;
    logic [1:0] sr_sync;
    logic       left_rise, right_rise;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] score_l_q, score_l_d, score_r_q, score_r_d;
    logic       dir_q, dir_d;
    logic [1:0] rem_q, rem_d;
    logic       step_q, step_d, padl_q, padl_d, padr_q, padr_d;
    logic       hold_q, hold_d, over_q, over_d;

    // Bits [1:0] synchronise; bit [2] delays the synced level for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            left_sync  <= '0;
            right_sync <= '0;
            sr_sync    <= '0;
            left_rise  <= 1'b0;
            right_rise <= 1'b0;
        end else begin
            left_sync  <= {left_sync[1:0], left};
            right_sync <= {right_sync[1:0], right};
            sr_sync    <= {sr_sync[0], score_reset};
            left_rise  <= left_sync[1] & ~left_sync[2];
            right_rise <= right_sync[1] & ~right_sync[2];
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        score_l_d = score_l_q;
        score_r_d = score_r_q;
        dir_d     = dir_q;
        rem_d     = rem_q;
        step_d    = 1'b0;
        padl_d    = 1'b0;
        padr_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (left_rise || right_rise) begin
                    state_d = SERVE;
                    cnt_d   = '0;
                end
            end
            SERVE: begin
                padl_d = frame_tick & left_sync[1];
                padr_d = frame_tick & right_sync[1];
                if (frame_tick) begin
                    if (cnt_q + 8'd1 == SERVE_N) begin
                        state_d = PLAY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            PLAY: begin
                padl_d = frame_tick & left_sync[1];
                padr_d = frame_tick & right_sync[1];
                if (miss_left || miss_right) begin
                    if (miss_left && score_r_q < WIN) score_r_d = score_r_q + 4'd1;
                    if (miss_right && score_l_q < WIN) score_l_d = score_l_q + 4'd1;
                    if (miss_left && !miss_right) dir_d = 1'b0;
                    if (miss_right && !miss_left) dir_d = 1'b1;
                    state_d = POINT;
                    cnt_d   = '0;
                    rem_d   = '0;
                end else if (rem_q != 2'd0) begin
                    // burst in progress: ticks arriving now are ignored
                    step_d = 1'b1;
                    rem_d  = rem_q - 2'd1;
                end else if (frame_tick) begin
                    step_d = 1'b1;
                    rem_d  = {speed_msb, speed_lsb};
                end
            end
            POINT: begin
                if (frame_tick) begin
                    if (cnt_q + 8'd1 == POINT_N) begin
                        cnt_d   = '0;
                        state_d = (score_l_q == WIN || score_r_q == WIN) ? OVER : SERVE;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            OVER: begin
                if (left_rise || right_rise) begin
                    score_l_d = '0;
                    score_r_d = '0;
                    cnt_d     = '0;
                    state_d   = SERVE;
                end
            end
            default: state_d = IDLE;
        endcase
        hold_d = !(state_d == PLAY || state_d == POINT);
        over_d = (state_d == OVER);
    end

    always_ff @(posedge clk) begin
        if (rst || sr_sync[1]) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            score_l_q <= '0;
            score_r_q <= '0;
            dir_q     <= 1'b1;
            rem_q     <= '0;
            step_q    <= 1'b0;
            padl_q    <= 1'b0;
            padr_q    <= 1'b0;
            hold_q    <= 1'b1;
            over_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            score_l_q <= score_l_d;
            score_r_q <= score_r_d;
            dir_q     <= dir_d;
            rem_q     <= rem_d;
            step_q    <= step_d;
            padl_q    <= padl_d;
            padr_q    <= padr_d;
            hold_q    <= hold_d;
            over_q    <= over_d;
        end
    end

    assign ball_step    = step_q;
    assign ball_hold    = hold_q;
    assign serve_dir    = dir_q;
    assign pad_left_up  = padl_q;
    assign pad_right_up = padr_q;
    assign score_left   = score_l_q;
    assign score_right  = score_r_q;
    assign game_over    = over_q;
    assign state        = state_q;

endmodule

// File: tb/tb_pong_game_sequencer.sv
// Directed bench for pong_game_sequencer: inputs driven and outputs sampled on
// the falling clock edge, expected values computed by hand.
module tb_pong_game_sequencer;

    logic       clk = 1'b0;
    logic       rst, frame_tick, left, right, score_reset;
    logic       speed_lsb, speed_msb, miss_left, miss_right;
    logic       ball_step, ball_hold, serve_dir, pad_left_up, pad_right_up, game_over;
    logic [3:0] score_left, score_right;
    logic [2:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    localparam int S_IDLE = 0, S_SERVE = 1, S_PLAY = 2, S_POINT = 3, S_OVER = 4;

    pong_game_sequencer #(.WIN_SCORE(9), .SERVE_FRAMES(60), .POINT_FRAMES(30)) dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .left(left), .right(right),
        .score_reset(score_reset), .speed_lsb(speed_lsb), .speed_msb(speed_msb),
        .miss_left(miss_left), .miss_right(miss_right), .ball_step(ball_step),
        .ball_hold(ball_hold), .serve_dir(serve_dir), .pad_left_up(pad_left_up),
        .pad_right_up(pad_right_up), .score_left(score_left), .score_right(score_right),
        .game_over(game_over), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // one frame tick followed by one idle cycle
    task automatic frames(input int n);
        repeat (n) begin
            frame_tick = 1'b1;
            cyc(1);
            frame_tick = 1'b0;
            cyc(1);
        end
    endtask

    task automatic tick_once(input logic [1:0] spd);
        {speed_msb, speed_lsb} = spd;
        frame_tick = 1'b1;
        cyc(1);
        frame_tick = 1'b0;
    endtask

    task automatic pulse_miss(input logic ml, input logic mr);
        miss_left  = ml;
        miss_right = mr;
        cyc(1);
        miss_left  = 1'b0;
        miss_right = 1'b0;
    endtask

    initial begin
        rst = 1'b1; frame_tick = 0; left = 0; right = 0; score_reset = 0;
        speed_lsb = 0; speed_msb = 0; miss_left = 0; miss_right = 0;
        cyc(3);
        check("rst_state", state, S_IDLE);
        check("rst_hold", ball_hold, 1);
        check("rst_dir", serve_dir, 1);
        check("rst_scores", {score_left, score_right}, 0);
        check("rst_over", game_over, 0);
        check("rst_step", ball_step, 0);
        rst = 1'b0;
        cyc(2);

        // left press: SERVE 4 cycles after pin
        left = 1'b1;
        cyc(3);
        check("press_idle_c3", state, S_IDLE);
        cyc(1);
        check("press_serve_c4", state, S_SERVE);
        tick_once(2'b00);
        check("serve_pad_l", pad_left_up, 1);
        check("serve_pad_r", pad_right_up, 0);
        left = 1'b0;
        cyc(4);
        frames(58);
        check("serve_59", state, S_SERVE);
        check("serve_hold", ball_hold, 1);
        frames(1);
        check("play_60", state, S_PLAY);
        check("play_hold", ball_hold, 0);

        // burst lengths
        tick_once(2'b10);
        check("b2_t1", ball_step, 1);
        cyc(1); check("b2_t2", ball_step, 1);
        cyc(1); check("b2_t3", ball_step, 1);
        cyc(1); check("b2_t4", ball_step, 0);
        cyc(2);
        tick_once(2'b00);
        check("b0_t1", ball_step, 1);
        cyc(1); check("b0_t2", ball_step, 0);

        // right paddle during PLAY
        right = 1'b1;
        cyc(4);
        tick_once(2'b00);
        check("play_pad_r", pad_right_up, 1);
        check("play_pad_l", pad_left_up, 0);
        right = 1'b0;
        cyc(4);
        check("play_still", state, S_PLAY);

        // miss_right mid-burst
        tick_once(2'b11);
        check("mb_t1", ball_step, 1);
        pulse_miss(1'b0, 1'b1);
        check("mb_step", ball_step, 0);
        check("mb_state", state, S_POINT);
        check("mb_score_l", score_left, 1);
        check("mb_dir", serve_dir, 1);
        check("mb_hold", ball_hold, 0);
        cyc(1); check("mb_step2", ball_step, 0);
        frames(29);
        check("point_29", state, S_POINT);
        frames(1);
        check("point_serve", state, S_SERVE);

        // misses in SERVE are ignored
        pulse_miss(1'b1, 1'b1);
        cyc(1);
        check("serve_miss", {score_left, score_right}, 8'h10);
        frames(60);
        check("play_again", state, S_PLAY);

        // simultaneous misses
        pulse_miss(1'b1, 1'b1);
        check("both_scores", {score_left, score_right}, 8'h21);
        check("both_dir", serve_dir, 1);
        frames(30);
        frames(60);

        // miss_left alone
        pulse_miss(1'b1, 1'b0);
        check("ml_scores", {score_left, score_right}, 8'h22);
        check("ml_dir", serve_dir, 0);
        frames(30);

        // drive score_left to 9
        for (int i = 0; i < 7; i++) begin
            frames(60);
            pulse_miss(1'b0, 1'b1);
            frames(30);
        end
        check("over_state", state, S_OVER);
        check("over_flag", game_over, 1);
        check("over_score_l", score_left, 9);
        check("over_score_r", score_right, 2);
        check("over_hold", ball_hold, 1);
        check("over_dir", serve_dir, 1);
        pulse_miss(1'b0, 1'b1);
        cyc(1);
        check("over_miss_ign", score_left, 9);

        // restart from OVER
        right = 1'b1;
        cyc(4);
        check("restart_state", state, S_SERVE);
        check("restart_scores", {score_left, score_right}, 0);
        check("restart_over", game_over, 0);
        right = 1'b0;
        cyc(4);
        frames(60);
        pulse_miss(1'b1, 1'b0);
        frames(30);
        frames(60);
        check("sr_pre_state", state, S_PLAY);
        check("sr_pre_score", score_right, 1);

        // score_reset mid-PLAY
        score_reset = 1'b1;
        cyc(2);
        check("sr_c2", state, S_PLAY);
        cyc(1);
        check("sr_c3", state, S_IDLE);
        check("sr_scores", {score_left, score_right}, 0);
        check("sr_hold", ball_hold, 1);
        score_reset = 1'b0;
        cyc(4);

        // rst during a burst
        left = 1'b1;
        cyc(4);
        left = 1'b0;
        cyc(4);
        frames(60);
        check("rb_play", state, S_PLAY);
        tick_once(2'b11);
        check("rb_t1", ball_step, 1);
        rst = 1'b1;
        cyc(1);
        check("rb_step", ball_step, 0);
        check("rb_state", state, S_IDLE);
        check("rb_pads", {pad_left_up, pad_right_up}, 0);
        rst = 1'b0;
        cyc(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pong_game_sequencer.md
Name: pong_game_sequencer

Overview:
- Frame-level game controller for the VGA pong datapath.
- Sequences serve, play, point-pause and game-over phases, and paces ball motion from the speed select inputs.
- Gates paddle motion from the left/right buttons and keeps both players' scores.
- Sits between the top-level input pins and the ball/paddle/score renderers; is clocked by the pixel clock and paced by a one-cycle frame tick from the VGA timing generator.

Parameters:
- WIN_SCORE, 9, score that ends the game; 1..15.
- SERVE_FRAMES, 60, frame ticks spent in SERVE before play starts; 1..255.
- POINT_FRAMES, 30, frame ticks spent frozen in POINT after a miss; 1..255.

Ports:
- clk  in  1  pixel clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- frame_tick  in  1  one-cycle pulse at start of vertical blank.
- left  in  1  left button, asynchronous level.
- right  in  1  right button, asynchronous level.
- score_reset  in  1  score-clear button, asynchronous level.
- speed_lsb  in  1  speed select, bit 0.
- speed_msb  in  1  speed select, bit 1.
- miss_left  in  1  pulse from ball datapath: ball passed left paddle.
- miss_right  in  1  pulse from ball datapath: ball passed right paddle.
- ball_step  out  1  pulse: advance ball one position.
- ball_hold  out  1  level: ball datapath holds ball at centre.
- serve_dir  out  1  initial ball direction; 0=toward left, 1=toward right.
- pad_left_up  out  1  pulse: move left paddle one step.
- pad_right_up  out  1  pulse: move right paddle one step.
- score_left  out  4  left player score.
- score_right  out  4  right player score.
- game_over  out  1  high in OVER.
- state  out  3  IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4.

Behaviour:
- Input synchronisation:
  - left, right and score_reset each pass through a 2-FF synchroniser.
  - A rising edge is flagged on the cycle after the second FF changes 0->1, i.e. 3 cycles after the pin.
  - Speed bits are sampled unsynchronised, and only on frame_tick.
- Reset (rst=1):
  - state=IDLE; scores 0; serve_dir=1; frame counter 0; step burst 0.
  - All pulse outputs 0; ball_hold=1; game_over=0.
- score_reset:
  - Synced level high: same effect as rst, except synchroniser flops keep running.
  - Priority: rst > score_reset > everything else.
- IDLE:
  - ball_hold=1; no steps, no paddle pulses.
  - Rising edge on left or right -> SERVE, frame counter cleared.
- SERVE:
  - ball_hold=1; paddle pulses enabled.
  - Frame counter increments on each frame_tick.
  - The tick that makes the count reach SERVE_FRAMES moves the FSM to PLAY on the next cycle.
- PLAY:
  - ball_hold=0; paddle pulses enabled.
  - On frame_tick, latch s={speed_msb,speed_lsb}.
  - Emit s+1 ball_step pulses on consecutive cycles T+1..T+1+s, where T is the tick cycle.
  - A new frame_tick during a burst is ignored; the burst is at most 4 cycles.
- Misses in PLAY:
  - miss_left: score_right+1, serve_dir=0.
  - miss_right: score_left+1, serve_dir=1.
  - Both in the same cycle: both scores increment, serve_dir unchanged.
  - Any miss -> POINT next cycle, remaining burst cancelled, frame counter cleared.
  - Scores saturate at WIN_SCORE.
  - Misses in any other state are ignored.
- POINT:
  - ball_hold=0, no ball_step (ball frozen); no paddle pulses.
  - After POINT_FRAMES ticks: if either score == WIN_SCORE -> OVER, else -> SERVE, counter cleared.
- OVER:
  - game_over=1, ball_hold=1.
  - Rising edge on left or right: both scores cleared and FSM -> SERVE in the same transition.
- Paddles (SERVE and PLAY only):
  - On frame_tick, a pulse on cycle T+1 for each synced button held.
  - pad_left_up follows left; pad_right_up follows right; either, both or neither may pulse.
- Output timing:
  - All outputs are registered.
  - state changes one cycle after the qualifying event.

Test Plan:
- Reset, then left pin high -> state=SERVE 4 cycles later; after 60 frame_ticks -> state=PLAY; ball_hold 1->0.
- PLAY with speed=2'b10, one frame_tick at cycle T -> ball_step high exactly at T+1, T+2, T+3; speed=2'b00 -> only at T+1.
- PLAY, miss_right pulse mid-burst -> score_left=1, serve_dir=1, no further ball_step, state=POINT; after 30 ticks -> SERVE.
- miss_left and miss_right in the same cycle -> both scores +1, serve_dir unchanged; misses injected in SERVE -> scores unchanged.
- Drive score_left to 9 via repeated miss_right -> POINT then OVER with game_over=1, score_left stays 9; right press -> scores 0, state=SERVE.
- score_reset held mid-PLAY -> 3 cycles later state=IDLE, scores 0, ball_hold=1; rst asserted during a step burst -> next cycle all pulses 0, state=IDLE.
